// File: rtl/conv_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_drain
// Purpose  : Walks every conv result bank in bank-major raster order and streams
//            each word downstream over valid/ready. Optional macro
//            CONV_DRAIN_RELU_EN clamps negative words to zero at the output.
// Revision : 1.0 - initial release
// ============================================================================
module conv_result_drain #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int CONV_RESULT_WIDTH  = 24,
    parameter int CONV_RESULT_HEIGHT = 24,
    parameter int BANK_NUM           = 6,
    parameter int READ_LATENCY       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  conv_done,
    output logic [2:0]            M10K_read_select,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] result_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_bank,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int c_WORDS = CONV_RESULT_WIDTH * CONV_RESULT_HEIGHT;
    localparam int c_DEPTH = READ_LATENCY + 2;
    localparam int c_PTR_W = $clog2(c_DEPTH);
    localparam int c_CNT_W = $clog2(c_DEPTH + 1);
    localparam int c_SUM_W = c_CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_READ  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_next_addr;
    logic [2:0]              r_next_bank;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [2:0]              r_rd_sel;
    logic [READ_LATENCY:0]   r_pipe_v;
    logic [2:0]              r_pipe_bank [READ_LATENCY+1];
    logic [DATA_WIDTH-1:0]   r_mem_data  [c_DEPTH];
    logic [2:0]              r_mem_bank  [c_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_valid;
    logic                    w_issue;
    logic                    w_last;
    logic                    w_drain_empty;
    logic [c_SUM_W-1:0]      w_inflight;
    logic [c_SUM_W-1:0]      w_used;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0]   w_head_proc;

    // The stage index READ_LATENCY lines up with valid result_in, so it pushes.
    assign w_push  = r_pipe_v[READ_LATENCY];
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && out_ready;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_pipe_v[i]);
        end
    end

    // A same-cycle pop frees a slot, which keeps the stream at one word per clock.
    assign w_used        = c_SUM_W'(r_count) + w_inflight;
    assign w_issue       = (r_state == S_READ) &&
                           (w_used < (c_SUM_W'(c_DEPTH) + c_SUM_W'(w_pop)));
    assign w_last        = (r_next_bank == 3'(BANK_NUM - 1)) &&
                           (r_next_addr == ADDR_WIDTH'(c_WORDS - 1));
    assign w_drain_empty = (w_inflight == '0) &&
                           ((r_count == '0) || ((r_count == c_CNT_W'(1)) && w_pop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ARM;
            S_ARM: begin
                busy = 1'b1;
                if (conv_done) w_state_nxt = S_READ;
            end
            S_READ: begin
                busy = 1'b1;
                if (w_issue && w_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (w_drain_empty) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next_addr <= '0;
            r_next_bank <= '0;
            r_rd_addr   <= '0;
            r_rd_sel    <= '0;
        end else if (r_state == S_IDLE || r_state == S_DONE) begin
            r_next_addr <= '0;
            r_next_bank <= '0;
            r_rd_addr   <= '0;
            r_rd_sel    <= '0;
        end else if (w_issue) begin
            r_rd_addr <= r_next_addr;
            r_rd_sel  <= r_next_bank;
            if (r_next_addr == ADDR_WIDTH'(c_WORDS - 1)) begin
                r_next_addr <= '0;
                r_next_bank <= r_next_bank + 3'd1;
            end else begin
                r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_v <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) r_pipe_bank[i] <= '0;
        end else begin
            r_pipe_v[0]    <= w_issue;
            r_pipe_bank[0] <= r_next_bank;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_bank[i] <= r_pipe_bank[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= result_in;
            r_mem_bank[r_wr_ptr] <= r_pipe_bank[READ_LATENCY];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(c_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(c_DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    assign w_head = r_mem_data[r_rd_ptr];

`ifdef CONV_DRAIN_RELU_EN
    assign w_head_proc = w_head[DATA_WIDTH-1] ? '0 : w_head;
`else
    assign w_head_proc = w_head;
`endif

    // Data is forced to zero while empty so every output reads 0 out of reset.
    assign out_valid        = w_valid;
    assign out_data         = w_valid ? w_head_proc : '0;
    assign out_bank         = w_valid ? r_mem_bank[r_rd_ptr] : 3'd0;
    assign read_address     = r_rd_addr;
    assign M10K_read_select = r_rd_sel;

endmodule
`default_nettype wire
